// File: rtl/torreta_rx_serial.sv
// ---------------------------------------------------------------------------
// torreta_rx_serial
//
// Receive side of the turret telemetry link. Deserializes 8N1 UART frames and
// parses the 8-character ASCII message "AAA,DDD#" (angle, distance, three
// decimal digits each). The last valid message is held as BCD digits for the
// seven-segment displays; framing and format problems are flagged on erro.
//
// Ports
//   clock              in   system clock
//   reset              in   synchronous, active-high reset
//   entrada_serial     in   UART line, idle high
//   angulo_*           out  BCD digits of the last valid angle
//   distancia_*        out  BCD digits of the last valid distance
//   mensagem_pronta    out  1-cycle pulse when a valid message is latched
//   erro               out  1-cycle pulse on framing or format error
//   byte_pronto        out  1-cycle pulse per correctly framed byte
//   dado_recebido      out  last correctly framed byte
//   db_estado          out  parser state code
//
// Receiver states
//   state      | meaning
//   OCIOSO     | line idle, waiting for a falling edge
//   INICIO     | timing to the middle of the start bit
//   DADOS      | sampling the 8 data bits, LSB first
//   PARADA     | sampling the stop bit
//
// Parser states (db_estado code)
//   state          | meaning
//   ESPERA_A2  (0) | waiting for angle hundreds digit
//   A1         (1) | waiting for angle tens digit
//   A0         (2) | waiting for angle units digit
//   VIRGULA    (3) | waiting for ','
//   D2         (4) | waiting for distance hundreds digit
//   D1         (5) | waiting for distance tens digit
//   D0         (6) | waiting for distance units digit
//   TERMINADOR (7) | waiting for '#'
//   ERRO_SINC  (8) | discarding bytes until '#'
// ---------------------------------------------------------------------------
module torreta_rx_serial #(
    parameter int CICLOS_POR_BIT = 434,
    parameter int LARGURA_CONT   = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [3:0] angulo_centena,
    output logic [3:0] angulo_dezena,
    output logic [3:0] angulo_unidade,
    output logic [3:0] distancia_centena,
    output logic [3:0] distancia_dezena,
    output logic [3:0] distancia_unidade,
    output logic       mensagem_pronta,
    output logic       erro,
    output logic       byte_pronto,
    output logic [7:0] dado_recebido,
    output logic [3:0] db_estado
);

    localparam logic [LARGURA_CONT-1:0] CONT_MEIO = LARGURA_CONT'(CICLOS_POR_BIT / 2);
    localparam logic [LARGURA_CONT-1:0] CONT_FIM  = LARGURA_CONT'(CICLOS_POR_BIT - 1);

    typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, PARADA} rx_estado_t;

    typedef enum logic [3:0] {
        ESPERA_A2  = 4'd0,
        A1         = 4'd1,
        A0         = 4'd2,
        VIRGULA    = 4'd3,
        D2         = 4'd4,
        D1         = 4'd5,
        D0         = 4'd6,
        TERMINADOR = 4'd7,
        ERRO_SINC  = 4'd8
    } ps_estado_t;

    // ---------------- input synchronizer and edge detect ----------------
    logic [1:0] sinc_q;
    logic       anterior_q;
    logic       rx_s;
    logic       borda;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_q     <= 2'b11;
            anterior_q <= 1'b1;
        end else begin
            sinc_q     <= {sinc_q[0], entrada_serial};
            anterior_q <= sinc_q[1];
        end
    end

    assign rx_s  = sinc_q[1];
    // A low line after a bad stop bit never looks like an edge, so the
    // receiver re-arms only once the line has been seen high again.
    assign borda = anterior_q & ~rx_s;

    // ---------------- receiver ----------------
    rx_estado_t             rx_q, rx_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d;
    logic [2:0]              idx_q, idx_d;
    logic [7:0]              desloc_q, desloc_d;
    logic                    amostra_ok;
    logic                    amostra_erro;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_q     <= OCIOSO;
            cont_q   <= '0;
            idx_q    <= '0;
            desloc_q <= '0;
        end else begin
            rx_q     <= rx_d;
            cont_q   <= cont_d;
            idx_q    <= idx_d;
            desloc_q <= desloc_d;
        end
    end

    always_comb begin
        rx_d     = rx_q;
        cont_d   = cont_q;
        idx_d    = idx_q;
        desloc_d = desloc_q;
        case (rx_q)
            OCIOSO: begin
                if (borda) begin
                    rx_d   = INICIO;
                    cont_d = '0;
                end
            end
            INICIO: begin
                if (cont_q == CONT_MEIO) begin
                    cont_d = '0;
                    if (rx_s) begin
                        rx_d = OCIOSO;
                    end else begin
                        rx_d  = DADOS;
                        idx_d = '0;
                    end
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            DADOS: begin
                if (cont_q == CONT_FIM) begin
                    cont_d   = '0;
                    desloc_d = {rx_s, desloc_q[7:1]};
                    if (idx_q == 3'd7) begin
                        rx_d = PARADA;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            PARADA: begin
                if (cont_q == CONT_FIM) begin
                    cont_d = '0;
                    rx_d   = OCIOSO;
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            default: begin
                rx_d   = OCIOSO;
                cont_d = '0;
            end
        endcase
    end

    always_comb begin
        amostra_ok   = 1'b0;
        amostra_erro = 1'b0;
        if (rx_q == PARADA && cont_q == CONT_FIM) begin
            amostra_ok   = rx_s;
            amostra_erro = ~rx_s;
        end
    end

    logic       byte_pronto_q;
    logic [7:0] dado_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_pronto_q <= 1'b0;
            dado_q        <= '0;
        end else begin
            byte_pronto_q <= amostra_ok;
            if (amostra_ok) begin
                dado_q <= desloc_q;
            end
        end
    end

    // ---------------- parser ----------------
    ps_estado_t ps_q, ps_d;
    logic       eh_digito;
    logic       eh_term;
    logic       aceito;
    logic       ignorado;
    logic       ps_erro;
    logic       ps_fim;
    logic       grava;

    assign eh_digito = (dado_q >= 8'h30) && (dado_q <= 8'h39);
    assign eh_term   = (dado_q == 8'h23);
    assign ignorado  = (ps_q == ESPERA_A2) && eh_term;

    always_comb begin
        aceito = 1'b0;
        case (ps_q)
            ESPERA_A2, A1, A0, D2, D1, D0: aceito = eh_digito;
            VIRGULA:                       aceito = (dado_q == 8'h2C);
            TERMINADOR, ERRO_SINC:         aceito = eh_term;
            default:                       aceito = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ps_q <= ESPERA_A2;
        end else begin
            ps_q <= ps_d;
        end
    end

    always_comb begin
        ps_d = ps_q;
        if (amostra_erro) begin
            ps_d = ESPERA_A2;
        end else if (byte_pronto_q) begin
            if (aceito) begin
                case (ps_q)
                    ESPERA_A2: ps_d = A1;
                    A1:        ps_d = A0;
                    A0:        ps_d = VIRGULA;
                    VIRGULA:   ps_d = D2;
                    D2:        ps_d = D1;
                    D1:        ps_d = D0;
                    D0:        ps_d = TERMINADOR;
                    default:   ps_d = ESPERA_A2;
                endcase
            end else if (ps_q != ERRO_SINC && !ignorado) begin
                // '#' itself is a message boundary, so resync immediately.
                ps_d = eh_term ? ESPERA_A2 : ERRO_SINC;
            end
        end
    end

    always_comb begin
        ps_erro = byte_pronto_q && !aceito && (ps_q != ERRO_SINC) && !ignorado;
        ps_fim  = byte_pronto_q && aceito && (ps_q == TERMINADOR);
        grava   = byte_pronto_q && aceito &&
                  (ps_q == ESPERA_A2 || ps_q == A1 || ps_q == A0 ||
                   ps_q == D2 || ps_q == D1 || ps_q == D0);
    end

    // Shadow digits: leftovers from an aborted message are always overwritten
    // before the next terminator can be reached, so they need no clearing.
    logic [3:0] sombra_q [6];
    logic [3:0] saida_q  [6];
    logic       erro_q;
    logic       msg_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                sombra_q[i] <= '0;
                saida_q[i]  <= '0;
            end
            erro_q <= 1'b0;
            msg_q  <= 1'b0;
        end else begin
            erro_q <= amostra_erro | ps_erro;
            msg_q  <= ps_fim;
            if (grava) begin
                case (ps_q)
                    ESPERA_A2: sombra_q[0] <= dado_q[3:0];
                    A1:        sombra_q[1] <= dado_q[3:0];
                    A0:        sombra_q[2] <= dado_q[3:0];
                    D2:        sombra_q[3] <= dado_q[3:0];
                    D1:        sombra_q[4] <= dado_q[3:0];
                    default:   sombra_q[5] <= dado_q[3:0];
                endcase
            end
            if (ps_fim) begin
                for (int i = 0; i < 6; i++) begin
                    saida_q[i] <= sombra_q[i];
                end
            end
        end
    end

    assign angulo_centena    = saida_q[0];
    assign angulo_dezena     = saida_q[1];
    assign angulo_unidade    = saida_q[2];
    assign distancia_centena = saida_q[3];
    assign distancia_dezena  = saida_q[4];
    assign distancia_unidade = saida_q[5];
    assign mensagem_pronta   = msg_q;
    assign erro              = erro_q;
    assign byte_pronto       = byte_pronto_q;
    assign dado_recebido     = dado_q;
    assign db_estado         = ps_q;

endmodule
